// File: rtl/host_param_bridge.sv
// host_param_bridge
//   Host-side register front end for ram_control's write port. The host
//   stages a symbol index, a parameter word and byte enables through 32-bit
//   register writes. A COMMIT write pushes the staged entry into a small FIFO.
//   A drain FSM then presents the FIFO head on hpb_wr_* and holds hpb_wr_req
//   until ram_control grants it with rcb_wr_done. The FIFO decouples the host
//   from the feed path, so host bursts never wait on arbitration.
//
// Ports
//   clk           clock
//   reset_n       synchronous, active-low reset
//   host_wr       host register write strobe
//   host_rd       host register read strobe
//   host_addr     register index (0..7)
//   host_wr_data  host write data
//   host_rd_data  registered read data
//   hpb_wr_addr   symbol index of FIFO head (0 when empty)
//   hpb_wr_data   parameter word of FIFO head (0 when empty)
//   hpb_wr_en     byte enables, only non-zero in the granted cycle
//   hpb_wr_req    registered write request
//   rcb_wr_done   same-cycle grant from ram_control
//   hpb_busy      FIFO non-empty or drain FSM not idle

module host_param_bridge #(
  parameter int HPB_RAM_WIDTH   = 64,
  parameter int HPB_FIFO_DEPTH  = 4,
  parameter int HPB_STALL_LIMIT = 100
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       host_wr,
  input  logic                       host_rd,
  input  logic [2:0]                 host_addr,
  input  logic [31:0]                host_wr_data,
  output logic [31:0]                host_rd_data,
  output logic [13:0]                hpb_wr_addr,
  output logic [HPB_RAM_WIDTH-1:0]   hpb_wr_data,
  output logic [HPB_RAM_WIDTH/8-1:0] hpb_wr_en,
  output logic                       hpb_wr_req,
  input  logic                       rcb_wr_done,
  output logic                       hpb_busy
);

  localparam int W  = HPB_RAM_WIDTH;
  localparam int BW = HPB_RAM_WIDTH / 8;
  localparam int PW = $clog2(HPB_FIFO_DEPTH);
  localparam int LW = $clog2(HPB_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t          state;
  logic [13:0]     sym_addr_q;
  logic [W-1:0]    data_q;
  logic [BW-1:0]   be_q;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic            ovf_q;
  logic            stall_q;
  logic [6:0]      stall_cnt;

  logic [13:0]     fifo_addr [HPB_FIFO_DEPTH];
  logic [W-1:0]    fifo_data [HPB_FIFO_DEPTH];
  logic [BW-1:0]   fifo_en   [HPB_FIFO_DEPTH];

  logic            wr_sym, wr_lo, wr_hi, wr_be, commit, status_wr;
  logic            full, head_valid, push, pop;
  logic [63:0]     data_ext, data_lo_next, data_hi_next;
  logic [6:0]      stall_inc;
  logic [31:0]     status_word;

  assign wr_sym    = host_wr && (host_addr == 3'd0);
  assign wr_lo     = host_wr && (host_addr == 3'd1);
  assign wr_hi     = host_wr && (host_addr == 3'd2);
  assign wr_be     = host_wr && (host_addr == 3'd3);
  assign commit    = host_wr && (host_addr == 3'd4);
  assign status_wr = host_wr && (host_addr == 3'd5);

  assign full       = (level == LW'(HPB_FIFO_DEPTH));
  assign head_valid = (level != '0);
  // A full FIFO drops the commit even if a pop frees a slot in the same cycle.
  assign push       = commit && !full;
  assign pop        = hpb_wr_req && rcb_wr_done;

  // The staged word is handled as 64 bits so the DATA_LO/DATA_HI halves map
  // the same way for every width; bits at or above W simply fall off.
  assign data_ext     = 64'(data_q);
  assign data_lo_next = {data_ext[63:32], host_wr_data};
  assign data_hi_next = {host_wr_data, data_ext[31:0]};

  assign stall_inc = (stall_cnt == 7'h7F) ? stall_cnt : stall_cnt + 7'd1;

  assign hpb_busy    = head_valid || (state != IDLE);
  assign status_word = {23'd0, 5'(level), stall_q, ovf_q, full, hpb_busy};

  assign hpb_wr_addr = head_valid ? fifo_addr[rd_ptr] : 14'd0;
  assign hpb_wr_data = head_valid ? fifo_data[rd_ptr] : '0;
  // Enables only appear in the granted cycle so feed-path reads never write.
  assign hpb_wr_en   = (head_valid ? fifo_en[rd_ptr] : '0) & {BW{pop}};

  // Staging registers hold their values across commits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sym_addr_q <= 14'd0;
      data_q     <= '0;
      be_q       <= '0;
    end else begin
      if (wr_sym) sym_addr_q <= host_wr_data[13:0];
      if (wr_lo)  data_q     <= data_lo_next[W-1:0];
      if (wr_hi)  data_q     <= data_hi_next[W-1:0];
      if (wr_be)  be_q       <= host_wr_data[BW-1:0];
    end
  end

  // FIFO storage needs no reset; the head is masked by head_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= sym_addr_q;
      fifo_data[wr_ptr] <= data_q;
      fifo_en[wr_ptr]   <= be_q;
    end
  end

  // Pointers, level and the overflow sticky (set wins over a clear).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
      if (commit && full)                        ovf_q <= 1'b1;
      else if (status_wr && host_wr_data[2])     ovf_q <= 1'b0;
    end
  end

  // Drain FSM with the stall counter and stall sticky. GAP enforces the one
  // idle request cycle that ram_control's ignore logic depends on.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      hpb_wr_req <= 1'b0;
      stall_cnt  <= 7'd0;
      stall_q    <= 1'b0;
    end else begin
      if (status_wr && host_wr_data[3]) stall_q <= 1'b0;
      case (state)
        IDLE: begin
          stall_cnt <= 7'd0;
          if (head_valid) begin
            state      <= REQ;
            hpb_wr_req <= 1'b1;
          end
        end
        REQ: begin
          stall_cnt <= rcb_wr_done ? 7'd0 : stall_inc;
          if (stall_inc == 7'(HPB_STALL_LIMIT)) stall_q <= 1'b1;
          if (rcb_wr_done) begin
            state      <= GAP;
            hpb_wr_req <= 1'b0;
          end
        end
        GAP: begin
          stall_cnt <= 7'd0;
          state     <= IDLE;
        end
        default: begin
          state      <= IDLE;
          hpb_wr_req <= 1'b0;
        end
      endcase
    end
  end

  // Registered read port; holds its value when host_rd is low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      host_rd_data <= 32'd0;
    end else if (host_rd) begin
      case (host_addr)
        3'd0:    host_rd_data <= {18'd0, sym_addr_q};
        3'd1:    host_rd_data <= data_ext[31:0];
        3'd2:    host_rd_data <= data_ext[63:32];
        3'd3:    host_rd_data <= 32'(be_q);
        3'd5:    host_rd_data <= status_word;
        default: host_rd_data <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_host_param_bridge.sv
// tb_host_param_bridge
//   Directed bench for host_param_bridge with hand-computed expectations.
//   A negedge monitor logs every write-enable pulse (cycle and address) so
//   drain order and spacing can be checked after each scenario.

module tb_host_param_bridge;

  logic        clk;
  logic        reset_n;
  logic        host_wr;
  logic        host_rd;
  logic [2:0]  host_addr;
  logic [31:0] host_wr_data;
  logic [31:0] host_rd_data;
  logic [13:0] hpb_wr_addr;
  logic [63:0] hpb_wr_data;
  logic [7:0]  hpb_wr_en;
  logic        hpb_wr_req;
  logic        rcb_wr_done;
  logic        hpb_busy;

  logic        tie_done;
  logic        done_drv;

  int          checks;
  int          passes;
  int          cyc;
  int          log_cyc [$];
  logic [13:0] log_addr [$];
  logic [31:0] rd;

  assign rcb_wr_done = tie_done ? hpb_wr_req : done_drv;

  host_param_bridge dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .host_wr      (host_wr),
    .host_rd      (host_rd),
    .host_addr    (host_addr),
    .host_wr_data (host_wr_data),
    .host_rd_data (host_rd_data),
    .hpb_wr_addr  (hpb_wr_addr),
    .hpb_wr_data  (hpb_wr_data),
    .hpb_wr_en    (hpb_wr_en),
    .hpb_wr_req   (hpb_wr_req),
    .rcb_wr_done  (rcb_wr_done),
    .hpb_busy     (hpb_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write-enable pulse log, sampled mid-cycle.
  always @(negedge clk) begin
    if (hpb_wr_en !== 8'h00) begin
      log_cyc.push_back(cyc);
      log_addr.push_back(hpb_wr_addr);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    host_addr    = a;
    host_wr_data = d;
    host_wr      = 1'b1;
    step(1);
    host_wr      = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    host_addr = a;
    host_rd   = 1'b1;
    step(1);
    host_rd   = 1'b0;
    d         = host_rd_data;
  endtask

  task automatic test_reset;
    tie_done = 1'b0;
    done_drv = 1'b0;
    reg_write(3'd0, 32'h0000_0155);
    reg_write(3'd1, 32'h1234_5678);
    reg_write(3'd2, 32'h9ABC_DEF0);
    reg_write(3'd3, 32'h0000_003C);
    reg_write(3'd4, 32'h0);
    step(2);
    reg_read(3'd0, rd);
    checks++; if (hpb_wr_req !== 1'b1) $display("[TB] FAIL pre_reset_req: got %0h expected 1", hpb_wr_req); else passes++;
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    checks++; if (hpb_wr_req !== 1'b0) $display("[TB] FAIL reset_req: got %0h expected 0", hpb_wr_req); else passes++;
    checks++; if (hpb_wr_en !== 8'h00) $display("[TB] FAIL reset_en: got %0h expected 0", hpb_wr_en); else passes++;
    checks++; if (hpb_wr_addr !== 14'h0) $display("[TB] FAIL reset_addr: got %0h expected 0", hpb_wr_addr); else passes++;
    checks++; if (hpb_wr_data !== 64'h0) $display("[TB] FAIL reset_data: got %0h expected 0", hpb_wr_data); else passes++;
    checks++; if (hpb_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0h expected 0", hpb_busy); else passes++;
    checks++; if (host_rd_data !== 32'h0) $display("[TB] FAIL reset_rd_data: got %0h expected 0", host_rd_data); else passes++;
    reg_read(3'd5, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL reset_status: got %0h expected 0", rd); else passes++;
    reg_read(3'd0, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL reset_sym_addr: got %0h expected 0", rd); else passes++;
  endtask

  task automatic test_single_write;
    reg_write(3'd0, 32'h0000_0123);
    reg_write(3'd1, 32'hCAFE_F00D);
    reg_write(3'd2, 32'hDEAD_BEEF);
    reg_write(3'd3, 32'h0000_00FF);
    reg_read(3'd0, rd);
    checks++; if (rd !== 32'h0000_0123) $display("[TB] FAIL rb_sym: got %0h expected 123", rd); else passes++;
    reg_read(3'd1, rd);
    checks++; if (rd !== 32'hCAFE_F00D) $display("[TB] FAIL rb_lo: got %0h expected cafef00d", rd); else passes++;
    reg_read(3'd2, rd);
    checks++; if (rd !== 32'hDEAD_BEEF) $display("[TB] FAIL rb_hi: got %0h expected deadbeef", rd); else passes++;
    reg_read(3'd3, rd);
    checks++; if (rd !== 32'h0000_00FF) $display("[TB] FAIL rb_be: got %0h expected ff", rd); else passes++;
    tie_done = 1'b1;
    reg_write(3'd4, 32'h0);
    checks++; if (hpb_wr_req !== 1'b0) $display("[TB] FAIL single_req_early: got %0h expected 0", hpb_wr_req); else passes++;
    checks++; if (hpb_busy !== 1'b1) $display("[TB] FAIL single_busy: got %0h expected 1", hpb_busy); else passes++;
    step(1);
    checks++; if (hpb_wr_req !== 1'b1) $display("[TB] FAIL single_req: got %0h expected 1", hpb_wr_req); else passes++;
    checks++; if (hpb_wr_en !== 8'hFF) $display("[TB] FAIL single_en: got %0h expected ff", hpb_wr_en); else passes++;
    checks++; if (hpb_wr_addr !== 14'h0123) $display("[TB] FAIL single_addr: got %0h expected 123", hpb_wr_addr); else passes++;
    checks++; if (hpb_wr_data !== 64'hDEAD_BEEF_CAFE_F00D) $display("[TB] FAIL single_data: got %0h expected deadbeefcafef00d", hpb_wr_data); else passes++;
    step(1);
    checks++; if (hpb_wr_req !== 1'b0 || hpb_wr_en !== 8'h00) $display("[TB] FAIL single_gap: got req=%0h en=%0h expected req=0 en=0", hpb_wr_req, hpb_wr_en); else passes++;
    checks++; if (hpb_busy !== 1'b1) $display("[TB] FAIL single_busy_gap: got %0h expected 1", hpb_busy); else passes++;
    step(1);
    checks++; if (hpb_busy !== 1'b0) $display("[TB] FAIL single_busy_clear: got %0h expected 0", hpb_busy); else passes++;
    tie_done = 1'b0;
  endtask

  task automatic test_grant_delay;
    int bad;
    tie_done = 1'b0;
    done_drv = 1'b0;
    reg_write(3'd0, 32'h0000_02A5);
    reg_write(3'd3, 32'h0000_000F);
    reg_write(3'd1, 32'h1111_1111);
    reg_write(3'd2, 32'h2222_2222);
    reg_write(3'd4, 32'h0);
    step(1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (hpb_wr_req !== 1'b1 || hpb_wr_addr !== 14'h02A5 ||
          hpb_wr_data !== 64'h2222_2222_1111_1111 || hpb_wr_en !== 8'h00) bad++;
      step(1);
    end
    checks++; if (bad != 0) $display("[TB] FAIL delay_hold: got %0d bad cycles expected 0", bad); else passes++;
    done_drv = 1'b1;
    #1;
    checks++; if (hpb_wr_en !== 8'h0F) $display("[TB] FAIL delay_en: got %0h expected f", hpb_wr_en); else passes++;
    @(posedge clk);
    #1;
    done_drv = 1'b0;
    checks++; if (hpb_wr_req !== 1'b0) $display("[TB] FAIL delay_req_drop: got %0h expected 0", hpb_wr_req); else passes++;
    step(1);
    checks++; if (hpb_wr_req !== 1'b0 || hpb_busy !== 1'b0) $display("[TB] FAIL delay_after: got req=%0h busy=%0h expected 0 0", hpb_wr_req, hpb_busy); else passes++;
  endtask

  task automatic test_back_to_back;
    int base;
    base = log_addr.size();
    tie_done = 1'b1;
    reg_write(3'd0, 32'h10);
    reg_write(3'd4, 32'h0);
    reg_write(3'd0, 32'h11);
    reg_write(3'd4, 32'h0);
    reg_write(3'd0, 32'h12);
    reg_write(3'd4, 32'h0);
    step(12);
    checks++;
    if (log_addr.size() - base != 3) begin
      $display("[TB] FAIL b2b_count: got %0d expected 3", log_addr.size() - base);
    end else if (log_addr[base] !== 14'h10 || log_addr[base+1] !== 14'h11 || log_addr[base+2] !== 14'h12) begin
      $display("[TB] FAIL b2b_order: got %0h %0h %0h expected 10 11 12", log_addr[base], log_addr[base+1], log_addr[base+2]);
    end else if (log_cyc[base+1] - log_cyc[base] != 3 || log_cyc[base+2] - log_cyc[base+1] != 3) begin
      $display("[TB] FAIL b2b_spacing: got %0d %0d expected 3 3", log_cyc[base+1] - log_cyc[base], log_cyc[base+2] - log_cyc[base+1]);
    end else passes++;
    tie_done = 1'b0;
  endtask

  task automatic test_overflow;
    int base;
    tie_done = 1'b0;
    done_drv = 1'b0;
    for (int k = 0; k < 5; k++) begin
      reg_write(3'd0, 32'h100 + 32'(k));
      reg_write(3'd4, 32'h0);
    end
    checks++; if (hpb_wr_addr !== 14'h100) $display("[TB] FAIL ovf_head: got %0h expected 100", hpb_wr_addr); else passes++;
    reg_read(3'd5, rd);
    checks++; if (rd !== 32'h47) $display("[TB] FAIL ovf_status: got %0h expected 47", rd); else passes++;
    reg_write(3'd5, 32'h4);
    reg_read(3'd5, rd);
    checks++; if (rd !== 32'h43) $display("[TB] FAIL ovf_clear: got %0h expected 43", rd); else passes++;
    // Commit while full in the same cycle as a grant: still dropped.
    base = log_addr.size();
    reg_write(3'd0, 32'h1FF);
    host_addr    = 3'd4;
    host_wr_data = 32'h0;
    host_wr      = 1'b1;
    done_drv     = 1'b1;
    step(1);
    host_wr      = 1'b0;
    done_drv     = 1'b0;
    reg_read(3'd5, rd);
    checks++; if (rd !== 32'h35) $display("[TB] FAIL ovf_pop_collide: got %0h expected 35", rd); else passes++;
    reg_write(3'd5, 32'h4);
    tie_done = 1'b1;
    step(15);
    checks++;
    if (log_addr.size() - base != 4) begin
      $display("[TB] FAIL ovf_drain_count: got %0d expected 4", log_addr.size() - base);
    end else if (log_addr[base] !== 14'h100 || log_addr[base+1] !== 14'h101 ||
                 log_addr[base+2] !== 14'h102 || log_addr[base+3] !== 14'h103) begin
      $display("[TB] FAIL ovf_drain_order: got %0h %0h %0h %0h expected 100 101 102 103",
               log_addr[base], log_addr[base+1], log_addr[base+2], log_addr[base+3]);
    end else passes++;
    reg_read(3'd5, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL ovf_final_status: got %0h expected 0", rd); else passes++;
    tie_done = 1'b0;
  endtask

  task automatic test_stall;
    tie_done = 1'b0;
    done_drv = 1'b0;
    reg_write(3'd0, 32'h3C3);
    reg_write(3'd4, 32'h0);
    step(1);
    checks++; if (hpb_wr_req !== 1'b1) $display("[TB] FAIL stall_req_rise: got %0h expected 1", hpb_wr_req); else passes++;
    step(99);
    reg_read(3'd5, rd);
    checks++; if (rd !== 32'h11) $display("[TB] FAIL stall_at_99: got %0h expected 11", rd); else passes++;
    reg_read(3'd5, rd);
    checks++; if (rd !== 32'h19) $display("[TB] FAIL stall_at_100: got %0h expected 19", rd); else passes++;
    checks++; if (hpb_wr_req !== 1'b1) $display("[TB] FAIL stall_req_held: got %0h expected 1", hpb_wr_req); else passes++;
    done_drv = 1'b1;
    #1;
    checks++; if (hpb_wr_en !== 8'h0F || hpb_wr_addr !== 14'h3C3) $display("[TB] FAIL stall_grant: got en=%0h addr=%0h expected f 3c3", hpb_wr_en, hpb_wr_addr); else passes++;
    @(posedge clk);
    #1;
    done_drv = 1'b0;
    step(1);
    reg_read(3'd5, rd);
    checks++; if (rd !== 32'h08) $display("[TB] FAIL stall_sticky: got %0h expected 8", rd); else passes++;
    reg_write(3'd5, 32'h8);
    reg_read(3'd5, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL stall_clear: got %0h expected 0", rd); else passes++;
  endtask

  task automatic test_mid_reset;
    int base;
    tie_done = 1'b0;
    done_drv = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      reg_write(3'd0, 32'h200 + 32'(k));
      reg_write(3'd4, 32'h0);
    end
    checks++; if (hpb_wr_req !== 1'b1) $display("[TB] FAIL midrst_req_pre: got %0h expected 1", hpb_wr_req); else passes++;
    base = log_addr.size();
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    checks++; if (hpb_wr_req !== 1'b0 || hpb_busy !== 1'b0) $display("[TB] FAIL midrst_req: got req=%0h busy=%0h expected 0 0", hpb_wr_req, hpb_busy); else passes++;
    tie_done = 1'b1;
    step(6);
    checks++; if (log_addr.size() - base != 0) $display("[TB] FAIL midrst_no_write: got %0d pulses expected 0", log_addr.size() - base); else passes++;
    reg_read(3'd5, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL midrst_status: got %0h expected 0", rd); else passes++;
    tie_done = 1'b0;
  endtask

  initial begin
    checks       = 0;
    passes       = 0;
    reset_n      = 1'b0;
    host_wr      = 1'b0;
    host_rd      = 1'b0;
    host_addr    = 3'd0;
    host_wr_data = 32'h0;
    tie_done     = 1'b0;
    done_drv     = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    test_reset();
    test_single_write();
    test_grant_delay();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
